// File: rtl/div_unit.sv
// Signed restoring divider: quotient -> lo_out, remainder -> hi_out; done DATA_W+2 cycles after start, no backpressure (start ignored unless idle).
// Optional DIV_ZERO_EXC_EN: a zero divisor finishes on the next cycle with div_zero and leaves hi_out/lo_out untouched.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              bz_q, bz_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
`ifdef DIV_ZERO_EXC_EN
    logic              dz_q, dz_d;
`endif

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              fits;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

    // Magnitude of the most-negative value is representable as unsigned, so no special case is needed.
    assign a_mag   = a_in[DATA_W-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag   = b_in[DATA_W-1] ? (~b_in + 1'b1) : b_in;
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = (shifted >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        bz_d    = bz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef DIV_ZERO_EXC_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    cnt_d   = '0;
                    q_neg_d = a_in[DATA_W-1] ^ b_in[DATA_W-1];
                    r_neg_d = a_in[DATA_W-1];
                    bz_d    = (b_in == '0);
`ifdef DIV_ZERO_EXC_EN
                    dz_d    = (b_in == '0);
                    state_d = (b_in == '0) ? S_DONE : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                rem_d = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A zero divisor yields all-ones regardless of dividend sign.
                hi_d    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                lo_d    = bz_q ? '1 : (q_neg_q ? (~quo_q + 1'b1) : quo_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef DIV_ZERO_EXC_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            bz_q    <= bz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef DIV_ZERO_EXC_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`ifdef DIV_ZERO_EXC_EN
    assign div_zero = (state_q == S_DONE) && dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table plus hand sequences for reset abort, re-start and divide-by-zero.
module tb_div_unit;
    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    div_unit #(.DATA_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    int           total = 0;
    int           bad   = 0;
    exp_t         sb[$];
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // mode bit0: pulse start while done is high; bit1: pulse start mid-CALC.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r,
                      input int lat, input logic dz, input int mode);
        exp_t e;
        int   n;
        bit   seen;
        bit   stable;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        sb.push_back('{q: q, r: r, dz: dz});
        n      = 0;
        seen   = 0;
        stable = 1;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
            a_in  = $urandom;
            b_in  = $urandom;
            @(negedge clk);
            if (done) begin
                seen = 1;
            end else begin
                if (!busy || lo_out !== prev_q || hi_out !== prev_r) stable = 0;
                if ((mode & 2) != 0 && n == 5) begin
                    start = 1'b1;
                    a_in  = 1;
                    b_in  = 1;
                end
            end
        end
        check("latency", W'(n), W'(lat));
        check("busy_hold_during_calc", W'(stable), W'(1));
        if (seen) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got done want no done");
            end else begin
                e = sb.pop_front();
                check("lo_out", lo_out, e.q);
                check("hi_out", hi_out, e.r);
                check("div_zero", W'(div_zero), W'(e.dz));
                check("busy_at_done", W'(busy), W'(1));
                if (!e.dz) begin
                    prev_q = e.q;
                    prev_r = e.r;
                end
            end
            if ((mode & 1) != 0) begin
                start = 1'b1;
                a_in  = 1;
                b_in  = 1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("done_one_cycle", W'(done), W'(0));
            check("busy_after_done", W'(busy), W'(0));
            if ((mode & 1) != 0) begin
                repeat (3) @(negedge clk);
                check("start_in_done_ignored", W'(busy), W'(0));
            end
        end
    endtask

    vec_t vecs[11];

    initial begin
        int extra;
        vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2};
        vecs[1]  = '{a: 32'hFFFFFFF9,   b: 32'd2,          q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF};
        vecs[2]  = '{a: 32'd7,          b: 32'hFFFFFFFE,   q: 32'hFFFFFFFD,   r: 32'd1};
        vecs[3]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'h80000000,   r: 32'd0};
        vecs[4]  = '{a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9,   q: 32'd14,         r: 32'hFFFFFFFE};
        vecs[5]  = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0};
        vecs[6]  = '{a: 32'd5,          b: 32'd10,         q: 32'd0,          r: 32'd5};
        vecs[7]  = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0};
        vecs[8]  = '{a: 32'h7FFFFFFF,   b: 32'h80000000,   q: 32'd0,          r: 32'h7FFFFFFF};
        vecs[9]  = '{a: 32'h80000000,   b: 32'h80000000,   q: 32'd1,          r: 32'd0};
        vecs[10] = '{a: 32'd12345678,   b: 32'd1000,       q: 32'd12345,      r: 32'd678};

        reset = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_div_zero", W'(div_zero), W'(0));
        check("rst_hi", hi_out, '0);
        check("rst_lo", lo_out, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, W + 2, 1'b0, (i == 0) ? 1 : 0);
        end

`ifdef DIV_ZERO_EXC_EN
        op(32'h1234, 32'd0, prev_q, prev_r, 1, 1'b1, 0);
`else
        op(32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, W + 2, 1'b0, 0);
`endif

        // Re-start mid-CALC is ignored: exactly one done with the first operands.
        op(32'd20, 32'd3, 32'd6, 32'd2, W + 2, 1'b0, 2);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("no_second_done", W'(extra), W'(0));

        // Reset in the middle of CALC aborts with no done pulse.
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'd50;
        b_in  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_div_zero", W'(div_zero), W'(0));
        check("abort_hi", hi_out, '0);
        check("abort_lo", lo_out, '0);
        prev_q = '0;
        prev_r = '0;
        extra  = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("abort_no_done", W'(extra), W'(0));
        op(32'd9, 32'd3, 32'd3, 32'd0, W + 2, 1'b0, 0);

        check("scoreboard_drained", W'(sb.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
